if_id_skid: RTL and testbench

IF_ID_SKID -- requirements
Module: if_id_skid

---
 rtl/if_id_skid.sv | 74 +++++++
 tb/tb_if_id_skid.sv | 139 +++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// if_id_skid: IF/ID pipeline register with one-entry skid buffer, stall, flush and field decode
module if_id_skid #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INST_W-1:0] inst_o,
  output logic [5:0]        op_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [5:0]        funct_o,
  output logic [15:0]       imm_o,
  output logic [25:0]       jaddr_o,
  output logic [1:0]        occupancy_o
);
  logic              out_v_q, out_v_d, sk_v_q, sk_v_d;
  logic [ADDR_W-1:0] out_a_q, out_a_d, sk_a_q, sk_a_d;
  logic [INST_W-1:0] out_i_q, out_i_d, sk_i_q, sk_i_d;
  logic [1:0]        occ_q, occ_d;
  logic              adv, acc;
  always_comb begin
    adv     = !out_v_q || !stall_i;
    acc     = valid_i && !sk_v_q;
    out_v_d = flush_i ? 1'b0 : adv ? (sk_v_q || acc) : out_v_q;
    out_a_d = flush_i || !adv ? out_a_q : sk_v_q ? sk_a_q : acc ? inst_addr_i : out_a_q;
    out_i_d = flush_i || !adv ? out_i_q : sk_v_q ? sk_i_q : acc ? inst_i : out_i_q;
    sk_v_d  = flush_i ? 1'b0 : adv ? 1'b0 : (sk_v_q || acc);
    sk_a_d  = !flush_i && !adv && acc ? inst_addr_i : sk_a_q;
    sk_i_d  = !flush_i && !adv && acc ? inst_i : sk_i_q;
    occ_d   = {1'b0, out_v_d} + {1'b0, sk_v_d};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_v_q <= 1'b0;
      out_a_q <= '0;
      out_i_q <= NOP_INST;
      sk_v_q  <= 1'b0;
      sk_a_q  <= '0;
      sk_i_q  <= NOP_INST;
      occ_q   <= '0;
    end else begin
      out_v_q <= out_v_d;
      out_a_q <= out_a_d;
      out_i_q <= out_i_d;
      sk_v_q  <= sk_v_d;
      sk_a_q  <= sk_a_d;
      sk_i_q  <= sk_i_d;
      occ_q   <= occ_d;
    end
  end
  assign ready_o     = !sk_v_q;
  assign valid_o     = out_v_q;
  assign inst_addr_o = out_a_q;
  assign inst_o      = out_v_q ? out_i_q : NOP_INST;
  assign occupancy_o = occ_q;
  assign op_o        = inst_o[31:26];
  assign rs_o        = inst_o[25:21];
  assign rt_o        = inst_o[20:16];
  assign rd_o        = inst_o[15:11];
  assign funct_o     = inst_o[5:0];
  assign imm_o       = inst_o[15:0];
  assign jaddr_o     = inst_o[25:0];
endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: randomized and directed checks of if_id_skid against a two-deep in-order queue model
module tb_if_id_skid;
  logic        clk_i = 0, rst_i = 0, valid_i = 0, stall_i = 0, flush_i = 0;
  logic [31:0] inst_addr_i = 0, inst_i = 0;
  logic        ready_o, valid_o;
  logic [31:0] inst_addr_o, inst_o;
  logic [5:0]  op_o, funct_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [15:0] imm_o;
  logic [25:0] jaddr_o;
  logic [1:0]  occupancy_o;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  typedef struct packed {logic [31:0] a; logic [31:0] i;} ent_t;
  ent_t q[$];
  logic [31:0] last_a = 0;

  if_id_skid dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .inst_addr_i(inst_addr_i), .inst_i(inst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_o), .inst_addr_o(inst_addr_o), .inst_o(inst_o), .op_o(op_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .funct_o(funct_o), .imm_o(imm_o),
    .jaddr_o(jaddr_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
    end
  endtask

  // Reference: entries held in arrival order, front is what the outputs show; room for two.
  always @(posedge clk_i) begin
    bit acc, adv;
    if (!rst_i) begin
      q.delete();
      last_a = 0;
    end else if (flush_i) q.delete();
    else begin
      acc = valid_i && q.size() < 2;
      adv = q.size() == 0 || !stall_i;
      if (adv && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{a: inst_addr_i, i: inst_i});
    end
    if (q.size() > 0) last_a = q[0].a;
  end

  always @(negedge clk_i) if (chk_en) begin
    logic [31:0] ei;
    ei = q.size() > 0 ? q[0].i : 32'h0;
    chk("valid_o", valid_o, q.size() > 0);
    chk("ready_o", ready_o, q.size() < 2);
    chk("occupancy_o", occupancy_o, q.size());
    chk("inst_o", inst_o, ei);
    chk("inst_addr_o", inst_addr_o, last_a);
    chk("op_o", op_o, ei[31:26]);
    chk("rs_o", rs_o, ei[25:21]);
    chk("rt_o", rt_o, ei[20:16]);
    chk("rd_o", rd_o, ei[15:11]);
    chk("funct_o", funct_o, ei[5:0]);
    chk("imm_o", imm_o, ei[15:0]);
    chk("jaddr_o", jaddr_o, ei[25:0]);
  end

  task automatic cyc(input bit r, input bit v, input logic [31:0] a, input logic [31:0] i,
                     input bit s, input bit f);
    rst_i = r; valid_i = v; inst_addr_i = a; inst_i = i; stall_i = s; flush_i = f;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    cyc(0, 1, 32'h99, 32'h1234, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk_en = 1;
    chk("rst valid_o", valid_o, 0);
    chk("rst inst_addr_o", inst_addr_o, 0);
    chk("rst ready_o", ready_o, 1);
    chk("rst occupancy_o", occupancy_o, 0);
    chk("rst inst_o", inst_o, 32'h0);
    cyc(1, 1, 32'h04, 32'hA, 0, 0);
    chk("stream addr 04", inst_addr_o, 32'h04);
    chk("stream ready 1", ready_o, 1);
    cyc(1, 1, 32'h08, 32'hB, 0, 0);
    chk("stream addr 08", inst_addr_o, 32'h08);
    chk("stream ready 2", ready_o, 1);
    cyc(1, 1, 32'h0C, 32'hC, 0, 0);
    chk("stream addr 0C", inst_addr_o, 32'h0C);
    chk("stream ready 3", ready_o, 1);
    cyc(1, 1, 32'h10, 32'h012A_4020, 0, 0);
    chk("dec op", op_o, 0);
    chk("dec rs", rs_o, 9);
    chk("dec rt", rt_o, 10);
    chk("dec rd", rd_o, 8);
    chk("dec funct", funct_o, 6'h20);
    chk("dec imm", imm_o, 16'h4020);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 32'h04, 32'h1, 0, 0);
    cyc(1, 1, 32'h08, 32'h2, 1, 0);
    chk("stall hold addr", inst_addr_o, 32'h04);
    chk("stall occ", occupancy_o, 2);
    chk("stall ready", ready_o, 0);
    cyc(1, 1, 32'h0C, 32'h3, 0, 0);
    chk("release addr 08", inst_addr_o, 32'h08);
    chk("release occ", occupancy_o, 1);
    cyc(1, 1, 32'h0C, 32'h3, 0, 0);
    chk("release addr 0C", inst_addr_o, 32'h0C);
    cyc(1, 1, 32'h20, 32'h5, 0, 0);
    cyc(1, 1, 32'h24, 32'h6, 1, 0);
    chk("pre-flush occ", occupancy_o, 2);
    cyc(1, 1, 32'h28, 32'h7, 1, 1);
    chk("flush valid_o", valid_o, 0);
    chk("flush inst_o", inst_o, 32'h0);
    chk("flush occ", occupancy_o, 0);
    chk("flush ready", ready_o, 1);
    cyc(1, 1, 32'h30, 32'h8, 0, 0);
    cyc(1, 1, 32'h34, 32'h9, 1, 0);
    chk("pre-reset occ", occupancy_o, 2);
    cyc(0, 1, 32'h38, 32'hA, 1, 1);
    chk("mid rst valid_o", valid_o, 0);
    chk("mid rst addr", inst_addr_o, 0);
    chk("mid rst ready", ready_o, 1);
    chk("mid rst occ", occupancy_o, 0);
    chk("mid rst inst_o", inst_o, 32'h0);
    cyc(1, 1, 32'h40, 32'hB, 1, 0);
    chk("post rst valid", valid_o, 1);
    chk("post rst addr", inst_addr_o, 32'h40);
    for (int n = 0; n < 12000; n++)
      cyc($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
          $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    cyc(1, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
